icache_ctrl: RTL and testbench

- Sequencing controller for the instruction-cache SRAM array (Icache_SRAM).
- Accepts fetch requests from the IF stage, performs the SRAM lookup and returns the instruction on a hit.
- On a miss, fetches the block from instruction memory as word beats, assembles it and writes it into the array with memWen. It then delivers the requested word from the fill buffer.
- Keeps saturating hit and miss counters for performance monitoring.

---
 rtl/icache_ctrl.sv | 139 +++++++++++++
 tb/tb_icache_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Instruction-cache sequencing controller: SRAM lookup, miss refill from
// memory in 32-bit beats, block write-back into the array and word delivery.
// Saturating hit/miss counters for performance monitoring.
module icache_ctrl #(
    parameter int TAG_W      = 22,
    parameter int SET_W      = 6,
    parameter int BLOCK_BITS = 128,
    parameter int WORDS      = BLOCK_BITS / 32,
    parameter int OFF_W      = $clog2(BLOCK_BITS / 8),
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_addr,
    output logic                    cpu_valid,
    output logic [31:0]             cpu_instr,
    output logic                    cpu_busy,
    output logic                    sram_ren,
    output logic                    sram_wen,
    output logic [TAG_W+SET_W-1:0]  sram_blockAddr,
    output logic [BLOCK_BITS-1:0]   sram_dataIn,
    input  logic                    sram_hit,
    input  logic [BLOCK_BITS-1:0]   sram_dataOut,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);

    localparam int BA_W  = TAG_W + SET_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StRefill,
        StWrite,
        StResp
    } state_e;

    state_e                  state_q;
    logic [BA_W-1:0]         blk_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        beat_q;
    logic [BLOCK_BITS-1:0]   fill_q;

    // Byte-within-word bits never select anything.
    logic unused_addr;
    assign unused_addr = ^cpu_addr[1:0];

    // State, latched request, fill buffer and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            blk_q    <= '0;
            idx_q    <= '0;
            beat_q   <= '0;
            fill_q   <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        blk_q   <= cpu_addr[OFF_W +: BA_W];
                        idx_q   <= cpu_addr[2 +: IDX_W];
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (sram_hit) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                        state_q <= StIdle;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                        state_q <= StMissReq;
                    end
                end
                StMissReq: state_q <= StRefill;
                StRefill: begin
                    // Gaps between beats simply hold the state.
                    if (mem_rvalid) begin
                        fill_q[{beat_q, 5'b0} +: 32] <= mem_rdata;
                        if (beat_q == IDX_W'(WORDS - 1)) begin
                            beat_q  <= '0;
                            state_q <= StWrite;
                        end else begin
                            beat_q <= beat_q + IDX_W'(1);
                        end
                    end
                end
                StWrite: state_q <= StResp;
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode from the registered state; the hit path uses sram_hit directly.
    always_comb begin
        cpu_valid      = 1'b0;
        cpu_instr      = '0;
        sram_ren       = 1'b0;
        sram_wen       = 1'b0;
        sram_blockAddr = blk_q;
        sram_dataIn    = fill_q;
        mem_req        = 1'b0;
        mem_addr       = '0;
        cpu_busy       = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                sram_ren       = cpu_req;
                sram_blockAddr = cpu_addr[OFF_W +: BA_W];
            end
            StLookup: begin
                if (sram_hit) begin
                    cpu_valid = 1'b1;
                    cpu_instr = sram_dataOut[{idx_q, 5'b0} +: 32];
                end
            end
            StMissReq: begin
                mem_req  = 1'b1;
                mem_addr = 32'({blk_q, {OFF_W{1'b0}}});
            end
            StWrite: sram_wen = 1'b1;
            StResp: begin
                // Deliver from the fill buffer; the array is not re-read.
                cpu_valid = 1'b1;
                cpu_instr = fill_q[{idx_q, 5'b0} +: 32];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: stimulus tasks push expected responses,
// writes and memory requests (with their expected cycle); a negedge monitor
// pops and compares whenever the DUT presents one.
module tb_icache_ctrl;

    localparam int TAG_W      = 22;
    localparam int SET_W      = 6;
    localparam int BLOCK_BITS = 128;
    localparam int CNT_W      = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cpu_req;
    logic [31:0]            cpu_addr;
    logic                   cpu_valid;
    logic [31:0]            cpu_instr;
    logic                   cpu_busy;
    logic                   sram_ren;
    logic                   sram_wen;
    logic [TAG_W+SET_W-1:0] sram_blockAddr;
    logic [BLOCK_BITS-1:0]  sram_dataIn;
    logic                   sram_hit;
    logic [BLOCK_BITS-1:0]  sram_dataOut;
    logic                   mem_req;
    logic [31:0]            mem_addr;
    logic                   mem_rvalid;
    logic [31:0]            mem_rdata;
    logic [CNT_W-1:0]       hit_cnt;
    logic [CNT_W-1:0]       miss_cnt;

    icache_ctrl #(
        .TAG_W(TAG_W),
        .SET_W(SET_W),
        .BLOCK_BITS(BLOCK_BITS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .cpu_valid(cpu_valid),
        .cpu_instr(cpu_instr),
        .cpu_busy(cpu_busy),
        .sram_ren(sram_ren),
        .sram_wen(sram_wen),
        .sram_blockAddr(sram_blockAddr),
        .sram_dataIn(sram_dataIn),
        .sram_hit(sram_hit),
        .sram_dataOut(sram_dataOut),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] instr; int cyc; } resp_t;
    typedef struct { logic [127:0] data; logic [27:0] blk; int cyc; } wr_t;
    typedef struct { logic [31:0] addr; int cyc; } mreq_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    mreq_t mreq_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every DUT-presented event against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_ren && sram_wen) chk("ren_wen_exclusive", 1, 0);
            if (cpu_valid) begin
                if (resp_q.size() == 0) chk("unexpected_cpu_valid", 1, 0);
                else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    chk("cpu_instr", cpu_instr, e.instr);
                    chk("resp_cycle", cyc, e.cyc);
                end
            end
            if (sram_wen) begin
                if (wr_q.size() == 0) chk("unexpected_sram_wen", 1, 0);
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("sram_dataIn", sram_dataIn, w.data);
                    chk("write_blockAddr", sram_blockAddr, w.blk);
                    chk("write_cycle", cyc, w.cyc);
                end
            end
            if (mem_req) begin
                if (mreq_q.size() == 0) chk("unexpected_mem_req", 1, 0);
                else begin
                    mreq_t m;
                    m = mreq_q.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_req_cycle", cyc, m.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cpu_valid"}, cpu_valid, 0);
        chk({tag, "_cpu_instr"}, cpu_instr, 0);
        chk({tag, "_cpu_busy"}, cpu_busy, 0);
        chk({tag, "_sram_ren"}, sram_ren, 0);
        chk({tag, "_sram_wen"}, sram_wen, 0);
        chk({tag, "_blockAddr"}, sram_blockAddr, 0);
        chk({tag, "_dataIn"}, sram_dataIn, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_hit_cnt"}, hit_cnt, 0);
        chk({tag, "_miss_cnt"}, miss_cnt, 0);
    endtask

    // Hit: response expected one cycle after acceptance.
    task automatic do_hit(input logic [31:0] addr, input logic [127:0] blk,
                          input logic [31:0] exp_instr);
        int c;
        c = cyc;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        resp_q.push_back('{exp_instr, c + 1});
        #2;
        chk("accept_ren", sram_ren, 1);
        chk("accept_blockAddr", sram_blockAddr, {4'b0, addr[31:4]});
        step();
        cpu_req      = 1'b0;
        sram_hit     = 1'b1;
        sram_dataOut = blk;
        step();
        sram_hit     = 1'b0;
        sram_dataOut = '0;
    endtask

    // Miss with refill; 'gap' idle cycles inserted between beats 1 and 2.
    task automatic do_miss(input logic [31:0] addr, input logic [127:0] blk,
                           input logic [31:0] exp_instr, input int gap, input bit noisy);
        int c;
        c = cyc;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        mreq_q.push_back('{{addr[31:4], 4'b0}, c + 2});
        wr_q.push_back('{blk, addr[31:4], c + 7 + gap});
        resp_q.push_back('{exp_instr, c + 8 + gap});
        step();
        cpu_req = 1'b0;
        step();
        chk("missreq_busy", cpu_busy, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rvalid = 1'b0;
                    if (noisy) begin
                        cpu_req  = ~cpu_req;
                        cpu_addr = $urandom;
                    end
                    step();
                end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = blk[32*i +: 32];
            step();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        step();
        step();
        step();
    endtask

    localparam logic [127:0] BLK_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BLK_B = 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1;
    localparam logic [127:0] BLK_C = 128'h0F0F0F0F_CAFEF00D_12345678_9ABCDEF0;

    initial begin
        rst          = 1'b1;
        cpu_req      = 1'b0;
        cpu_addr     = '0;
        sram_hit     = 1'b0;
        sram_dataOut = '0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        step();
        step();
        chk_all_zero("por");
        rst = 1'b0;
        step();

        // Reset asserted mid-refill after two beats.
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0500;
        mreq_q.push_back('{32'h0000_0500, cyc + 2});
        step();
        cpu_req = 1'b0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5555_0000 + i;
            step();
        end
        mem_rvalid = 1'b0;
        cpu_addr   = '0;
        rst        = 1'b1;
        step();
        step();
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_0000 + i;
            step();
        end
        mem_rvalid = 1'b0;
        repeat (6) step();
        chk("post_rst_idle", cpu_busy, 0);

        // Cold miss, then hit to the same block.
        do_miss(32'h0000_0108, BLK_A, 32'h3333_3333, 0, 1'b0);
        chk("miss_cnt_1", miss_cnt, 1);
        chk("hit_cnt_0", hit_cnt, 0);
        do_hit(32'h0000_010C, BLK_A, 32'h4444_4444);
        chk("hit_cnt_1", hit_cnt, 1);

        // Gapped refill with input noise during the refill.
        do_miss(32'h0000_2004, BLK_B, 32'hB2B2_B2B2, 3, 1'b1);
        chk("miss_cnt_2", miss_cnt, 2);

        // Stray beats in IDLE must not shift the next fill.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        step();
        mem_rvalid = 1'b0;
        do_miss(32'h0000_300C, BLK_C, 32'h0F0F_0F0F, 0, 1'b0);
        chk("miss_cnt_3", miss_cnt, 3);

        // Counter saturation at 3 (CNT_W = 2).
        do_hit(32'h0000_3000, BLK_C, 32'h9ABC_DEF0);
        chk("hit_cnt_2", hit_cnt, 2);
        do_hit(32'h0000_3008, BLK_C, 32'hCAFE_F00D);
        chk("hit_cnt_3", hit_cnt, 3);
        do_hit(32'h0000_3004, BLK_C, 32'h1234_5678);
        chk("hit_cnt_sat", hit_cnt, 3);
        do_miss(32'h0000_0100, BLK_A, 32'h1111_1111, 1, 1'b0);
        chk("miss_cnt_sat", miss_cnt, 3);

        repeat (3) step();
        chk("resp_q_drained", resp_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("mreq_q_drained", mreq_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
